button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_pkg.sv | 14 +
 rtl/button_if.sv | 14 +
 rtl/button_detect.sv | 32 +++
 rtl/debounce_cell.sv | 58 +++++
 rtl/button_conditioner.sv | 50 +++++
 tb/tb_button_conditioner.sv | 234 +++++++++++++++++++++++
 6 files changed

// File: rtl/button_pkg.sv
// Shared constants and payload types for the button conditioner and press detector.
package button_pkg;

  localparam int unsigned N_BTN_DEF           = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1250000;
  localparam int unsigned CODE_W              = 2;

  typedef struct packed {
    logic              valid;
    logic [CODE_W-1:0] code;
    logic              multi;
  } press_evt_t;

endpackage

// File: rtl/button_if.sv
// Press event bus: per-channel next-cycle pulses in, summarised press event out.
interface button_if
  import button_pkg::*;
#(
  parameter int unsigned N_BTN = N_BTN_DEF
);

  logic [N_BTN-1:0] btn;
  press_evt_t       evt;

  modport master (output btn, input  evt);
  modport slave  (input  btn, output evt);

endinterface

// File: rtl/button_detect.sv
// Summarises the upcoming press pulses into valid/lowest-index/multiple flags, registered
// so they land in the same cycle as the pulses themselves.
module button_detect
  import button_pkg::*;
#(
  parameter int unsigned N_BTN = N_BTN_DEF
) (
  input logic     clk,
  input logic     clr_n,
  button_if.slave bus
);

  press_evt_t evt_q, evt_d;

  // Descending scan so the lowest set index is the one that sticks.
  always_comb begin
    evt_d       = '0;
    evt_d.valid = |bus.btn;
    evt_d.multi = |(bus.btn & (bus.btn - N_BTN'(1)));
    for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
      if (bus.btn[i]) evt_d.code = CODE_W'(i);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) evt_q <= '0;
    else        evt_q <= evt_d;
  end

  assign bus.evt = evt_q;

endmodule

// File: rtl/debounce_cell.sv
// One button channel: two-flop synchronizer, stability counter, debounced level, press pulse.
module debounce_cell
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic clr_n,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o,
  output logic pulse_nxt_c_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q, pulse_d;

  // Any cycle where the synchronized input agrees with the level drops all accumulated credit.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s2_q;
        pulse_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o       = level_q;
  assign pulse_o       = pulse_q;
  assign pulse_nxt_c_o = pulse_d;

endmodule

// File: rtl/button_conditioner.sv
// Debounces N_BTN raw buttons and reports accepted presses as aligned one-cycle events.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned N_BTN           = N_BTN_DEF
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [N_BTN-1:0]  BTN_raw,
  output logic [N_BTN-1:0]  btn_level,
  output logic [N_BTN-1:0]  press_pulse,
  output logic              press_valid,
  output logic [CODE_W-1:0] press_code,
  output logic              press_multi
);

  logic [N_BTN-1:0] pulse_nxt_c;

  button_if #(.N_BTN(N_BTN)) evt_bus ();

  for (genvar g = 0; g < int'(N_BTN); g++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk           (clk),
      .clr_n         (clr_n),
      .raw_i         (BTN_raw[g]),
      .level_o       (btn_level[g]),
      .pulse_o       (press_pulse[g]),
      .pulse_nxt_c_o (pulse_nxt_c[g])
    );
  end

  // Detector sees next-cycle pulses bit-for-bit so its registered flags align with press_pulse.
  assign evt_bus.btn = pulse_nxt_c;

  button_detect #(
    .N_BTN(N_BTN)
  ) u_detect (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (evt_bus.slave)
  );

  assign press_valid = evt_bus.evt.valid;
  assign press_code  = evt_bus.evt.code;
  assign press_multi = evt_bus.evt.multi;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner with a short debounce window: directed table, corner
// sequences, and randomized traffic against a history-window reference model.
module tb_button_conditioner;

  localparam int unsigned D = 4;
  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         clr_n;
  logic [N-1:0] BTN_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] press_pulse;
  logic         press_valid;
  logic [1:0]   press_code;
  logic         press_multi;

  int n_chk = 0;
  int n_err = 0;

  always #4 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .N_BTN          (N)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .BTN_raw    (BTN_raw),
    .btn_level  (btn_level),
    .press_pulse(press_pulse),
    .press_valid(press_valid),
    .press_code (press_code),
    .press_multi(press_multi)
  );

  typedef struct {
    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] pulse;
    logic       valid;
    logic [1:0] code;
    logic       multi;
  } vec_t;

  vec_t tbl[$];

  // Reference model: a level flips once the last D synchronized samples all disagree with it.
  logic [3:0] hist[$];
  logic [3:0] m_level;
  logic [3:0] m_pulse;

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < int'(D) + 2; i++) hist.push_front(4'b0000);
    m_level = '0;
    m_pulse = '0;
  endtask

  task automatic model_step(input logic [3:0] raw);
    logic v;
    logic same;
    hist.push_front(raw);
    if (hist.size() > int'(D) + 2) void'(hist.pop_back());
    m_pulse = '0;
    for (int ch = 0; ch < 4; ch++) begin
      v    = hist[2][ch];
      same = 1'b1;
      for (int j = 2; j < int'(D) + 2; j++) if (hist[j][ch] != v) same = 1'b0;
      if (same && v != m_level[ch]) begin
        m_level[ch] = v;
        m_pulse[ch] = v;
      end
    end
  endtask

  function automatic logic [1:0] lowest(input logic [3:0] v);
    logic [1:0] r = 2'd0;
    logic found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[i] && !found) begin
        r = 2'(i);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [3:0] el, input logic [3:0] ep,
                     input logic ev, input logic [1:0] ec, input logic em);
    n_chk++;
    if ({btn_level, press_pulse, press_valid, press_code, press_multi} !== {el, ep, ev, ec, em}) begin
      n_err++;
      $display("FAIL %s t=%0t: got level=%b pulse=%b valid=%b code=%0d multi=%b, want level=%b pulse=%b valid=%b code=%0d multi=%b",
               name, $time, btn_level, press_pulse, press_valid, press_code, press_multi,
               el, ep, ev, ec, em);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench mid-cycle with reset released and inputs low.
  task automatic do_reset();
    clr_n   = 1'b0;
    BTN_raw = '0;
    repeat (2) @(posedge clk);
    #2 clr_n = 1'b1;
    model_reset();
  endtask

  task automatic add(input logic [3:0] raw, input logic [3:0] level, input logic [3:0] pulse,
                     input logic [1:0] code, input logic multi);
    vec_t v;
    v.raw   = raw;
    v.level = level;
    v.pulse = pulse;
    v.valid = |pulse;
    v.code  = code;
    v.multi = multi;
    tbl.push_back(v);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int pulses;
    logic [3:0] cur;

    // Directed table, edge k counted from the first edge that samples the new input.
    for (int k = 1; k <= 13; k++)
      add(4'b0100, (k >= 6) ? 4'b0100 : 4'b0000, (k == 6) ? 4'b0100 : 4'b0000,
          (k == 6) ? 2'd2 : 2'd0, 1'b0);
    for (int k = 1; k <= 8; k++)
      add(4'b0000, (k >= 6) ? 4'b0000 : 4'b0100, 4'b0000, 2'd0, 1'b0);
    for (int k = 1; k <= 8; k++)
      add(4'b1010, (k >= 6) ? 4'b1010 : 4'b0000, (k == 6) ? 4'b1010 : 4'b0000,
          (k == 6) ? 2'd1 : 2'd0, (k == 6));

    clr_n   = 1'b0;
    BTN_raw = '0;
    repeat (2) @(posedge clk);
    #1 chk("reset_state", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    #1 clr_n = 1'b1;
    model_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      BTN_raw = tbl[i].raw;
      tick();
      chk($sformatf("table[%0d]", i), tbl[i].level, tbl[i].pulse, tbl[i].valid,
          tbl[i].code, tbl[i].multi);
    end

    // Bounce on channel 3: 1,0,1 then hold; final rise is sampled at edge 3.
    do_reset();
    pulses = 0;
    BTN_raw = 4'b1000; tick(); chk("bounce_e1", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    BTN_raw = 4'b0000; tick(); chk("bounce_e2", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    BTN_raw = 4'b1000; tick(); chk("bounce_e3", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      pulses += $countones(press_pulse);
      chk($sformatf("bounce_early%0d", k), 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    end
    tick();
    pulses += $countones(press_pulse);
    chk("bounce_pulse", 4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick();
      pulses += $countones(press_pulse);
    end
    n_chk++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL bounce_pulse_count: got %0d pulses, want 1", pulses);
    end

    // Reset asserted mid-debounce with channel 0 held high throughout.
    do_reset();
    BTN_raw = 4'b0001;
    tick();
    tick();
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1 chk("async_clear", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("in_reset%0d", k), 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    end
    #1 clr_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("post_rst_e%0d", k), 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    end
    tick(); chk("post_rst_pulse", 4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0);
    tick(); chk("post_rst_after", 4'b0001, 4'b0000, 1'b0, 2'd0, 1'b0);

    // Glitch on channel 1 shorter than the debounce window.
    do_reset();
    for (int k = 0; k < 11; k++) begin
      BTN_raw = (k < 3) ? 4'b0010 : 4'b0000;
      tick();
      chk($sformatf("glitch%0d", k), 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    end

    // Randomized traffic with occasional asynchronous resets.
    do_reset();
    cur = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 11) == 0) cur[b] = ~cur[b];
      BTN_raw = cur;
      @(posedge clk);
      model_step(cur);
      #1;
      chk("random", m_level, m_pulse, |m_pulse, lowest(m_pulse), $countones(m_pulse) > 1);
      if ($urandom_range(0, 599) == 0) begin
        #1 clr_n = 1'b0;
        model_reset();
        #1 chk("random_async_rst", 4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
        @(posedge clk);
        #2 clr_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
